// File: rtl/spi_master_ctrl_if.sv
// Host command port and SPI pins of the 10-bit-frame SPI master.
interface spi_master_ctrl_if;
    logic       start;
    logic [1:0] cmd;
    logic [7:0] payload;
    logic       busy;
    logic       done;
    logic       rd_valid;
    logic [7:0] rd_data;
    logic       SS_n;
    logic       MOSI;
    logic       MISO;

    modport master (
        input  start, cmd, payload, MISO,
        output busy, done, rd_valid, rd_data, SS_n, MOSI
    );

    modport slave (
        output start, cmd, payload, MISO,
        input  busy, done, rd_valid, rd_data, SS_n, MOSI
    );
endinterface

// File: rtl/spi_master_ctrl.sv
// SPI master for the 10-bit-frame slave protocol: serialises {cmd, payload}
// on SS_n/MOSI and, for rd-data frames, captures 8 bits from MISO.
module spi_master_ctrl #(
    parameter int unsigned RD_LATENCY = 3,
    parameter int unsigned GAP_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    spi_master_ctrl_if.master bus
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SELECT,
        ST_CMD,
        ST_SHIFT,
        ST_HOLD,
        ST_RD_WAIT,
        ST_RD_SHIFT,
        ST_END
    } state_t;

    state_t     state;
    logic [9:0] frame;
    logic [3:0] bit_cnt;
    logic [3:0] wait_cnt;
    logic [2:0] gap_cnt;
    logic [7:0] rx_shift;
    logic       frame_end;   // set on the END->IDLE edge, marks the IDLE entry cycle

    // State machine, counters, MISO capture and registered outputs. Outputs are
    // registered from the state held during the cycle that just ended, so each
    // state's pin values appear one cycle after the state is entered.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            frame        <= '0;
            bit_cnt      <= '0;
            wait_cnt     <= '0;
            gap_cnt      <= '0;
            rx_shift     <= '0;
            frame_end    <= 1'b0;
            bus.SS_n     <= 1'b1;
            bus.MOSI     <= 1'b0;
            bus.busy     <= 1'b0;
            bus.done     <= 1'b0;
            bus.rd_valid <= 1'b0;
            bus.rd_data  <= '0;
        end else begin
            bus.busy     <= (state != ST_IDLE);
            bus.SS_n     <= (state == ST_IDLE) || (state == ST_END);
            bus.done     <= (state == ST_IDLE) && frame_end;
            bus.rd_valid <= (state == ST_IDLE) && frame_end && (frame[9:8] == 2'b11);
            if ((state == ST_IDLE) && frame_end && (frame[9:8] == 2'b11)) begin
                bus.rd_data <= rx_shift;
            end

            case (state)
                ST_CMD:   bus.MOSI <= frame[9];
                ST_SHIFT: bus.MOSI <= frame[4'd9 - bit_cnt];
                default:  bus.MOSI <= 1'b0;
            endcase

            frame_end <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        frame <= {bus.cmd, bus.payload};
                        state <= ST_SELECT;
                    end
                end
                ST_SELECT: state <= ST_CMD;
                ST_CMD: begin
                    bit_cnt <= '0;
                    state   <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    if (bit_cnt == 4'd9) begin
                        bit_cnt <= '0;
                        state   <= (frame[9:8] == 2'b11) ? ST_RD_WAIT : ST_HOLD;
                    end else begin
                        bit_cnt <= bit_cnt + 4'd1;
                    end
                end
                ST_HOLD: begin
                    gap_cnt <= '0;
                    state   <= ST_END;
                end
                ST_RD_WAIT: begin
                    if (wait_cnt == 4'(RD_LATENCY - 1)) begin
                        wait_cnt <= '0;
                        bit_cnt  <= '0;
                        state    <= ST_RD_SHIFT;
                    end else begin
                        wait_cnt <= wait_cnt + 4'd1;
                    end
                end
                ST_RD_SHIFT: begin
                    rx_shift <= {rx_shift[6:0], bus.MISO};
                    if (bit_cnt == 4'd7) begin
                        bit_cnt <= '0;
                        gap_cnt <= '0;
                        state   <= ST_END;
                    end else begin
                        bit_cnt <= bit_cnt + 4'd1;
                    end
                end
                ST_END: begin
                    if (gap_cnt == 3'(GAP_CYCLES - 1)) begin
                        gap_cnt   <= '0;
                        frame_end <= 1'b1;
                        state     <= ST_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + 3'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Directed bench for spi_master_ctrl: table of single frames plus hand
// sequences for start-while-busy, back-to-back, mid-frame reset and RD_LATENCY=1.
module tb_spi_master_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    spi_master_ctrl_if bus0 ();
    spi_master_ctrl_if bus1 ();

    spi_master_ctrl #(.RD_LATENCY(3), .GAP_CYCLES(1)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0)
    );

    spi_master_ctrl #(.RD_LATENCY(1), .GAP_CYCLES(1)) u_dut_lat1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        string       name;
        logic [1:0]  cmd;
        logic [7:0]  pl;
        logic [7:0]  miso;
        logic [10:0] stream;    // MOSI cycles 2..12, first bit in MSB
        int          ss_last;
        int          done_cyc;
        logic        rdv;
        logic [7:0]  rd_data;
    } vec_t;

    typedef struct {
        int          ss_first;
        int          ss_last;
        int          low_cnt;
        int          done_cyc;
        int          done_cnt;
        int          busy_cnt;
        int          mosi_extra;
        int          stray_rdv;
        logic [10:0] stream;
        logic        rdv;
        logic [7:0]  rd_data;
    } obs_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int sel, input logic st, input logic [1:0] c, input logic [7:0] p);
        if (sel == 1) begin
            bus1.start = st; bus1.cmd = c; bus1.payload = p;
        end else begin
            bus0.start = st; bus0.cmd = c; bus0.payload = p;
        end
    endtask

    task automatic set_miso(input int sel, input logic b);
        if (sel == 1) bus1.MISO = b;
        else          bus0.MISO = b;
    endtask

    // One frame from the accepting edge (cycle 0) through cycle 40.
    task automatic run_frame(input int sel, input logic [1:0] c_cmd, input logic [7:0] c_pl,
                             input logic [7:0] miso_b, input int lat, input int inj,
                             output obs_t o);
        logic ss, mo, dn, rv, bz;
        logic [7:0] rd;
        o.ss_first = -1; o.ss_last = -1; o.low_cnt = 0; o.done_cyc = -1;
        o.done_cnt = 0; o.busy_cnt = 0; o.mosi_extra = 0; o.stray_rdv = 0;
        o.stream = '0; o.rdv = 1'b0; o.rd_data = '0;
        drive(sel, 1'b1, c_cmd, c_pl);
        set_miso(sel, 1'b1);
        tick();
        drive(sel, 1'b0, ~c_cmd, ~c_pl);
        for (int c = 1; c <= 40; c++) begin
            tick();
            ss = (sel == 1) ? bus1.SS_n     : bus0.SS_n;
            mo = (sel == 1) ? bus1.MOSI     : bus0.MOSI;
            dn = (sel == 1) ? bus1.done     : bus0.done;
            rv = (sel == 1) ? bus1.rd_valid : bus0.rd_valid;
            bz = (sel == 1) ? bus1.busy     : bus0.busy;
            rd = (sel == 1) ? bus1.rd_data  : bus0.rd_data;
            if (!ss) begin
                o.low_cnt++;
                if (o.ss_first < 0) o.ss_first = c;
                o.ss_last = c;
            end
            if (c >= 2 && c <= 12) o.stream = {o.stream[9:0], mo};
            else if (mo) o.mosi_extra++;
            if (bz) o.busy_cnt++;
            if (dn) begin
                o.done_cnt++;
                if (o.done_cyc < 0) begin
                    o.done_cyc = c; o.rdv = rv; o.rd_data = rd;
                end
            end
            if (rv && !dn) o.stray_rdv++;
            if (c >= 12 + lat && c <= 19 + lat) set_miso(sel, miso_b[7 - (c - 12 - lat)]);
            else                                set_miso(sel, 1'b1);
            if (c == inj)          drive(sel, 1'b1, 2'b01, 8'hFF);
            else if (c == inj + 1) drive(sel, 1'b0, 2'b01, 8'hFF);
        end
    endtask

    task automatic check_frame(input string nm, input obs_t o, input logic [10:0] stream,
                               input int ss_last, input int done_cyc, input logic rdv,
                               input logic [7:0] rd_data);
        check({nm, " ss_first"},   o.ss_first,   1);
        check({nm, " ss_last"},    o.ss_last,    ss_last);
        check({nm, " ss_lowcnt"},  o.low_cnt,    ss_last);
        check({nm, " mosi"},       32'(o.stream), 32'(stream));
        check({nm, " mosi_idle"},  o.mosi_extra, 0);
        check({nm, " done_cyc"},   o.done_cyc,   done_cyc);
        check({nm, " done_cnt"},   o.done_cnt,   1);
        check({nm, " busy_cnt"},   o.busy_cnt,   done_cyc - 1);
        check({nm, " rd_valid"},   32'(o.rdv),   32'(rdv));
        check({nm, " stray_rdv"},  o.stray_rdv,  0);
        check({nm, " rd_data"},    32'(o.rd_data), 32'(rd_data));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        obs_t o;
        logic [50:0] ss_hist;
        logic [10:0] strm;
        int dcyc[$];
        int dcount;

        vecs[0] = '{"wr_addr_A5", 2'b00, 8'hA5, 8'h00, 11'h0A5, 13, 15, 1'b0, 8'h00};
        vecs[1] = '{"wr_data_5A", 2'b01, 8'h5A, 8'h00, 11'h15A, 13, 15, 1'b0, 8'h00};
        vecs[2] = '{"rd_addr_C3", 2'b10, 8'hC3, 8'h00, 11'h6C3, 13, 15, 1'b0, 8'h00};
        vecs[3] = '{"rd_data_3C", 2'b11, 8'h00, 8'h3C, 11'h700, 23, 25, 1'b1, 8'h3C};
        vecs[4] = '{"rd_data_A5", 2'b11, 8'h96, 8'hA5, 11'h796, 23, 25, 1'b1, 8'hA5};
        vecs[5] = '{"wr_hold_rd", 2'b00, 8'h3C, 8'h00, 11'h03C, 13, 15, 1'b0, 8'hA5};

        drive(0, 1'b0, 2'b00, 8'h00);
        drive(1, 1'b0, 2'b00, 8'h00);
        set_miso(0, 1'b1);
        set_miso(1, 1'b1);
        rst_n = 1'b0;
        repeat (3) tick();
        check("reset SS_n",     32'(bus0.SS_n),     1);
        check("reset MOSI",     32'(bus0.MOSI),     0);
        check("reset busy",     32'(bus0.busy),     0);
        check("reset done",     32'(bus0.done),     0);
        check("reset rd_valid", 32'(bus0.rd_valid), 0);
        check("reset rd_data",  32'(bus0.rd_data),  0);
        rst_n = 1'b1;
        repeat (2) tick();

        for (int i = 0; i < 6; i++) begin
            run_frame(0, vecs[i].cmd, vecs[i].pl, vecs[i].miso, 3, -10, o);
            check_frame(vecs[i].name, o, vecs[i].stream, vecs[i].ss_last,
                        vecs[i].done_cyc, vecs[i].rdv, vecs[i].rd_data);
        end

        // start with other cmd/payload at cycle 5 must be ignored
        run_frame(0, 2'b00, 8'hA5, 8'h00, 3, 5, o);
        check_frame("start_busy", o, 11'h0A5, 13, 15, 1'b0, 8'hA5);

        // back-to-back with start held high
        ss_hist = '0;
        strm = '0;
        drive(0, 1'b1, 2'b01, 8'h0F);
        tick();
        for (int c = 1; c <= 50; c++) begin
            tick();
            ss_hist[c] = bus0.SS_n;
            if (bus0.done) dcyc.push_back(c);
            if (c >= 17 && c <= 27) strm = {strm[9:0], bus0.MOSI};
            if (c == 40) drive(0, 1'b0, 2'b01, 8'h0F);
        end
        check("b2b done_count", dcyc.size(), 3);
        if (dcyc.size() == 3) begin
            check("b2b done1", dcyc[0], 15);
            check("b2b done2", dcyc[1], 30);
            check("b2b done3", dcyc[2], 45);
        end
        check("b2b gap1",   32'(ss_hist[16:13]), 32'h6);
        check("b2b gap2",   32'(ss_hist[31:28]), 32'h6);
        check("b2b stop",   32'(ss_hist[50:44]), 32'h7F);
        check("b2b mosi2",  32'(strm),           32'h10F);

        // completed read, then reset at cycle 7 of the next rd-data frame
        run_frame(0, 2'b11, 8'h00, 8'h3C, 3, -10, o);
        check_frame("pre_reset_rd", o, 11'h700, 23, 25, 1'b1, 8'h3C);
        drive(0, 1'b1, 2'b11, 8'h00);
        tick();
        drive(0, 1'b0, 2'b11, 8'h00);
        repeat (6) tick();
        check("abort ss_low_before", 32'(bus0.SS_n), 0);
        rst_n = 1'b0;
        tick();
        check("abort SS_n",    32'(bus0.SS_n),     1);
        check("abort busy",    32'(bus0.busy),     0);
        check("abort done",    32'(bus0.done),     0);
        check("abort rd_data", 32'(bus0.rd_data),  0);
        rst_n = 1'b1;
        dcount = 0;
        for (int c = 0; c < 30; c++) begin
            tick();
            if (bus0.done || bus0.rd_valid || !bus0.SS_n) dcount++;
        end
        check("abort quiet", dcount, 0);
        run_frame(0, 2'b00, 8'hA5, 8'h00, 3, -10, o);
        check_frame("post_reset", o, 11'h0A5, 13, 15, 1'b0, 8'h00);

        // RD_LATENCY=1 instance
        run_frame(1, 2'b11, 8'h00, 8'h81, 1, -10, o);
        check_frame("lat1_rd_81", o, 11'h700, 21, 23, 1'b1, 8'h81);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_master_ctrl.md
Name: spi_master_ctrl

Overview:
- Single-clock SPI master. It is the initiator side of the team's 10-bit-frame SPI slave/RAM-wrapper protocol.
- Accepts one command from a host port: 2-bit cmd plus 8-bit payload. Serialises it on SS_n/MOSI in the exact cycle framing the slave decodes.
- For read-data frames, keeps SS_n low after the command and captures 8 bits returned on MISO.
- Lives in the testbench/wrapper level as the stimulus driver and in SoC integration as the bus master.

Parameters:
- RD_LATENCY, 3: clk cycles of SS_n-low wait between the last MOSI frame bit and the first MISO sample on a read-data frame. Legal range 1..15.
- GAP_CYCLES, 1: clk cycles SS_n is held high in END before returning to IDLE. Legal range 1..7.

Ports:
- clk  in  1  system clock; SPI bit rate = clk.
- rst_n  in  1  reset, synchronous, active-low.
- start  in  1  host request; sampled only in IDLE.
- cmd  in  2  frame command: 00 wr-addr, 01 wr-data, 10 rd-addr, 11 rd-data.
- payload  in  8  address/data byte; ignored for rd-data content but still shifted.
- busy  out  1  high from the cycle after start is accepted until return to IDLE.
- done  out  1  1-cycle pulse on the IDLE entry cycle after every frame.
- rd_valid  out  1  1-cycle pulse coincident with done, only for cmd=11.
- rd_data  out  8  captured MISO byte; holds until the next rd-data frame completes.
- SS_n  out  1  slave select, active-low.
- MOSI  out  1  serial data to slave.
- MISO  in  1  serial data from slave.

Behaviour:
- All outputs are registered.
- Reset values: SS_n=1, MOSI=0, busy=0, done=0, rd_valid=0, rd_data=0x00. The FSM resets to IDLE and all counters to 0.
- Reset is honoured in any state. A reset mid-frame aborts the frame: SS_n=1 on the next edge, no done pulse.
- Frame word F[9:0] = {cmd, payload}, latched on acceptance and stable for the whole frame.
- Cycle numbering: cycle 0 is the clk edge that samples start=1 in IDLE.

FSM states:
- IDLE: SS_n=1, MOSI=0, busy=0.
  - start=1 → latch cmd/payload, go to SELECT.
  - start=0 → stay.
- SELECT (cycle 1): SS_n=0, MOSI=0, busy=1. The slave leaves its idle state. Next state: CMD.
- CMD (cycle 2): MOSI=F[9], the read/write select bit. Next state: SHIFT.
- SHIFT (cycles 3..12): MOSI=F[9-i], i=0..9, MSB first; 4-bit bit counter.
  - After i=9: cmd=11 → RD_WAIT; otherwise → HOLD.
- HOLD (cycle 13): SS_n=0, MOSI=0. Gives the slave its rx_valid cycle. Next state: END.
- RD_WAIT: SS_n=0, MOSI=0 for RD_LATENCY cycles. Next state: RD_SHIFT.
- RD_SHIFT: 8 cycles, SS_n=0, MOSI=0.
  - MISO is sampled at each clk edge into a shift register, MSB first: the first sample becomes rd_data[7].
  - After 8 samples → END.
- END: SS_n=1, MOSI=0, busy=1 for GAP_CYCLES cycles. Next state: IDLE.
- IDLE entry cycle: done=1, busy=0. rd_valid=1 and rd_data updated, same cycle, iff the frame was cmd=11.
- start is also sampled in the done cycle, so frames can run back-to-back. The minimum SS_n-high gap is GAP_CYCLES+1.

Latency and handshake:
- Write, wr-data and rd-addr frames: SS_n low cycles 1..13; done at cycle 14+GAP_CYCLES (cycle 15 at default).
- Rd-data frames: SS_n low cycles 1..12+RD_LATENCY+8; done at cycle 13+RD_LATENCY+8+GAP_CYCLES (cycle 25 at default).
- start while busy=1 is ignored, not queued. cmd/payload changes during busy have no effect.
- rd_data is not altered by non-read frames or by aborted frames.

Width rules:
- Bit counter saturates at no value and never wraps within a state; it clears on every state change.
- The RD_WAIT counter is 4 bits wide.

Test Plan:
- Write-addr: start with cmd=00, payload=0xA5. Required: SS_n low cycles 1..13; MOSI cycles 2..12 = 0,0,0,1,0,1,0,0,1,0,1; done at cycle 15; rd_valid stays 0.
- Rd-data, MISO returning 0x3C: cmd=11, payload=0x00, default params, slave model drives MISO bits 0,0,1,1,1,1,0,0 during RD_SHIFT cycles 16..23. Required: rd_data=0x3C with rd_valid=done=1 at cycle 25; SS_n high from cycle 24.
- Start while busy: second start with cmd=01, payload=0xFF at cycle 5. Required: ignored; the MOSI stream of frame 1 is unchanged and exactly one done pulse occurs.
- Back-to-back: start held high continuously with cmd=01, payload=0x0F. Required: frames repeat with SS_n high exactly 2 cycles between them and a done pulse every 15 cycles.
- Reset mid-frame: rst_n=0 at cycle 7 of an rd-data frame that follows a completed read returning 0x3C. Required: next edge SS_n=1, busy=0, done=0; rd_data=0x00 after reset; the next frame starts cleanly from SELECT.
- RD_LATENCY=1 instance with MISO returning 0x81. Required: first sample at cycle 14, rd_data=0x81, done at cycle 23.
